data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words stored (power of two, 4..65536).
REQ-002 The block SHALL have parameter LATENCY, default 2: extra wait cycles between request acceptance and response (0..15).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req_valid  input  1  processor presents a load/store request.
REQ-006 The block SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-007 The block SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr  input  32  byte address.
REQ-009 The block SHALL have port req_wdata  input  32  store data.
REQ-010 The block SHALL have port req_wstrb  input  4  byte enables; bit i selects byte lane [8i+7:8i].
REQ-011 The block SHALL have port resp_valid  output  1  response available.
REQ-012 The block SHALL have port resp_ready  input  1  processor accepts the response.
REQ-013 The block SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 The block SHALL have port resp_err  output  1  misaligned or out-of-range access.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT, RESP; exactly one request outstanding.
REQ-016 req_ready SHALL be 1 only in IDLE and not in reset; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-017 On acceptance, a LATENCY-cycle counter SHALL load; next state is WAIT if LATENCY>0, else RESP.
REQ-018 In WAIT the counter SHALL decrement each cycle; the transition to RESP SHALL occur when the counter reaches 1, so resp_valid first rises LATENCY+1 cycles after the acceptance edge.
REQ-019 An access SHALL be in error if req_addr[1:0]!=0 or req_addr >= 4*DEPTH_WORDS; errors perform no write, give resp_err=1 and resp_rdata=0.
REQ-020 A valid store SHALL update memory on the acceptance edge; a valid load SHALL capture word req_addr[log2(DEPTH_WORDS)+1:2] on the acceptance edge into the response register.
REQ-021 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be held stable until resp_ready=1.
REQ-022 On the edge with resp_valid=1 and resp_ready=1 the FSM SHALL return to IDLE; req_ready is then 1 on the following cycle (no same-cycle acceptance).
REQ-023 resp_ready asserted outside RESP SHALL be ignored; req_valid outside IDLE SHALL be ignored.
REQ-024 A store followed by a load to the same word SHALL return the stored data.

Reset
REQ-025 While rst=1 at a rising edge: state SHALL become IDLE, counter 0, resp_valid 0, resp_err 0, resp_rdata 0; req_ready SHALL read 0 during reset.
REQ-026 Reset mid-transaction (WAIT or RESP) SHALL drop the pending response; a store already accepted remains written.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With macro DMEM_BYTE_STRB_EN defined, stores SHALL write only byte lanes whose req_wstrb bit is 1; req_wstrb=0 writes nothing but still responds without error.
REQ-029 Without DMEM_BYTE_STRB_EN, req_wstrb SHALL be ignored and every valid store SHALL write all 32 bits.

Verification
REQ-030 LATENCY=2: store 0xDEADBEEF to 0x10 accepted at cycle 0 -> resp_valid=1 at cycle 3, resp_err=0, resp_rdata=0; load 0x10 -> resp_rdata=0xDEADBEEF.
REQ-031 Load from 0x13 -> resp_err=1, resp_rdata=0; load from 0x400 with DEPTH_WORDS=256 -> resp_err=1; memory unchanged.
REQ-032 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable all 5 cycles; req_ready=0 throughout; req_ready=1 the cycle after resp_ready=1.
REQ-033 LATENCY=0: load accepted at cycle 0 -> resp_valid=1 at cycle 1.
REQ-034 DMEM_BYTE_STRB_EN defined: word 0x20 = 0x11223344, store 0xAABBCCDD wstrb=0101 -> load returns 0x11BB33DD; macro undefined -> 0xAABBCCDD.
REQ-035 rst=1 for one cycle while in WAIT -> resp_valid never asserts, req_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port word memory behind a valid/ready request/response handshake.
//   Exactly one request is outstanding at a time. After a request is
//   accepted, the response appears LATENCY+1 cycles later and is held until
//   the requester takes it.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, 4..65536)
//   LATENCY     : extra wait cycles between acceptance and response (0..15)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle (IDLE, not in reset)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address [31:0]
//   req_wdata  in   store data [31:0]
//   req_wstrb  in   byte enables [3:0] (only with DMEM_BYTE_STRB_EN)
//   resp_valid out  response available
//   resp_ready in   response accepted
//   resp_rdata out  load data [31:0]; 0 for stores and errors
//   resp_err   out  misaligned or out-of-range access
//
// Build option
//   DMEM_BYTE_STRB_EN : when defined, stores write only the byte lanes whose
//                       req_wstrb bit is set; otherwise every valid store
//                       writes the full word.
//
// Memory contents are not affected by reset.

module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW         = $clog2(DEPTH_WORDS);
   localparam int unsigned BYTE_LIMIT = 4 * DEPTH_WORDS;
   localparam logic [3:0]  LAT        = 4'(LATENCY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_accept;
   logic          w_err;
   logic [AW-1:0] w_idx;

   assign req_ready  = (r_state == IDLE) && !rst;
   assign resp_valid = (r_state == RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

   assign w_accept = req_valid && req_ready;
   assign w_err    = (req_addr[1:0] != 2'b00) || (req_addr >= BYTE_LIMIT);
   assign w_idx    = req_addr[AW+1:2];

`ifndef DMEM_BYTE_STRB_EN
   // Strobes have no effect in the full-word build.
   logic w_unused_strb;
   assign w_unused_strb = ^req_wstrb;
`endif

   // Control FSM and response register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_err   <= w_err;
                  r_rdata <= (w_err || req_we) ? '0 : r_mem[w_idx];
                  r_cnt   <= LAT;
                  r_state <= (LAT != 4'd0) ? WAIT : RESP;
               end
            end
            WAIT: begin
               // Leaving on count==1 makes the total delay LATENCY+1 cycles.
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Storage array; writes happen on the acceptance edge of a valid store.
   always_ff @(posedge clk) begin
      if (w_accept && req_we && !w_err) begin
`ifdef DMEM_BYTE_STRB_EN
         for (int unsigned i = 0; i < 4; i++) begin
            if (req_wstrb[i]) begin
               r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
`else
         r_mem[w_idx] <= req_wdata;
`endif
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;

   // Default instance: DEPTH_WORDS=256, LATENCY=2
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   // Zero-latency instance
   logic        req_valid0, req_ready0, req_we0;
   logic [31:0] req_addr0, req_wdata0;
   logic [3:0]  req_wstrb0;
   logic        resp_valid0, resp_ready0, resp_err0;
   logic [31:0] resp_rdata0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
      .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
      .resp_valid(resp_valid0), .resp_ready(resp_ready0),
      .resp_rdata(resp_rdata0), .resp_err(resp_err0)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic rdy_of(input int sel);
      return (sel != 0) ? req_ready0 : req_ready;
   endfunction

   function automatic logic rv_of(input int sel);
      return (sel != 0) ? resp_valid0 : resp_valid;
   endfunction

   task automatic drive_req(input int sel, input logic v, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb);
      if (sel != 0) begin
         req_valid0 = v; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata; req_wstrb0 = wstrb;
      end else begin
         req_valid = v; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
      end
   endtask

   // One full transaction; lat = negedges from acceptance edge to resp_valid, -1 on timeout.
   task automatic xact(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       output logic err, output logic [31:0] rdata, output int lat);
      int n;
      lat = -1; err = 1'bx; rdata = 'x;
      @(negedge clk);
      n = 0;
      while (!rdy_of(sel) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rdy_of(sel)) return;
      drive_req(sel, 1'b1, we, addr, wdata, wstrb);
      @(posedge clk);
      #1 drive_req(sel, 1'b0, 1'b0, '0, '0, '0);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (rv_of(sel)) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) return;
      if (sel != 0) begin
         err = resp_err0; rdata = resp_rdata0; resp_ready0 = 1'b1;
      end else begin
         err = resp_err; rdata = resp_rdata; resp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      resp_ready0 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        e;
      logic [31:0] d;
      logic [31:0] exp_strb;
      int          lat;
      int          seen;

      rst = 1'b1;
      resp_ready = 1'b0;
      resp_ready0 = 1'b0;
      drive_req(0, 1'b0, 1'b0, '0, '0, '0);
      drive_req(1, 1'b0, 1'b0, '0, '0, '0);

      vecs[0]  = '{"st_10",      1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
      vecs[1]  = '{"ld_10",      1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'hDEADBEEF};
      vecs[2]  = '{"ld_13_mis",  1'b0, 32'h13,       32'h0,        4'hF, 1'b1, 32'h0};
      vecs[3]  = '{"ld_400_oor", 1'b0, 32'h400,      32'h0,        4'hF, 1'b1, 32'h0};
      vecs[4]  = '{"st_12_mis",  1'b1, 32'h12,       32'h12345678, 4'hF, 1'b1, 32'h0};
      vecs[5]  = '{"ld_10_again",1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'hDEADBEEF};
      vecs[6]  = '{"st_3fc",     1'b1, 32'h3FC,      32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
      vecs[7]  = '{"st_0",       1'b1, 32'h0,        32'h00000001, 4'hF, 1'b0, 32'h0};
      vecs[8]  = '{"st_400_oor", 1'b1, 32'h400,      32'h00000055, 4'hF, 1'b1, 32'h0};
      vecs[9]  = '{"st_hi_oor",  1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
      vecs[10] = '{"ld_0",       1'b0, 32'h0,        32'h0,        4'hF, 1'b0, 32'h00000001};
      vecs[11] = '{"ld_3fc",     1'b0, 32'h3FC,      32'h0,        4'hF, 1'b0, 32'hCAFEF00D};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req_ready", {31'b0, req_ready}, 32'h1);

      // Table-driven transactions
      for (int i = 0; i < 12; i++) begin
         xact(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, e, d, lat);
         chk({vecs[i].name, "_lat"}, 32'(lat), 32'd3);
         chk({vecs[i].name, "_err"}, {31'b0, e}, {31'b0, vecs[i].exp_err});
         chk({vecs[i].name, "_rdata"}, d, vecs[i].exp_rdata);
      end

      // Backpressure: response held for 5 cycles, concurrent request ignored
      @(negedge clk);
      drive_req(0, 1'b1, 1'b0, 32'h10, '0, 4'hF);
      @(posedge clk);
      #1 drive_req(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF);
      seen = 0;
      for (int k = 0; k < 40 && !resp_valid; k++) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk("bp_resp_valid", {31'b0, resp_valid}, 32'h1);
         chk("bp_rdata", resp_rdata, 32'hDEADBEEF);
         chk("bp_req_ready", {31'b0, req_ready}, 32'h0);
         @(negedge clk);
      end
      drive_req(0, 1'b0, 1'b0, '0, '0, '0);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      chk("bp_after_req_ready", {31'b0, req_ready}, 32'h1);
      chk("bp_after_resp_valid", {31'b0, resp_valid}, 32'h0);
      xact(0, 1'b0, 32'h10, '0, 4'hF, e, d, lat);
      chk("bp_ignored_store", d, 32'hDEADBEEF);

      // resp_ready held high outside RESP is ignored
      resp_ready = 1'b1;
      @(negedge clk);
      drive_req(0, 1'b1, 1'b0, 32'h3FC, '0, 4'hF);
      @(posedge clk);
      #1 drive_req(0, 1'b0, 1'b0, '0, '0, '0);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (resp_valid) begin lat = k; break; end
      end
      chk("rr_early_lat", 32'(lat), 32'd3);
      chk("rr_early_rdata", resp_rdata, 32'hCAFEF00D);
      @(posedge clk);
      #1 resp_ready = 1'b0;

      // Byte strobes
      xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, e, d, lat);
      xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, e, d, lat);
      chk("strb_store_err", {31'b0, e}, 32'h0);
      xact(0, 1'b0, 32'h20, '0, 4'hF, e, d, lat);
`ifdef DMEM_BYTE_STRB_EN
      exp_strb = 32'h11BB33DD;
`else
      exp_strb = 32'hAABBCCDD;
`endif
      chk("strb_load", d, exp_strb);
      xact(0, 1'b1, 32'h24, 32'h01020304, 4'h0, e, d, lat);
      chk("strb_zero_err", {31'b0, e}, 32'h0);

      // Reset while in WAIT: pending response dropped, accepted store kept
      @(negedge clk);
      drive_req(0, 1'b1, 1'b1, 32'h44, 32'h0BADF00D, 4'hF);
      @(posedge clk);
      #1 drive_req(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("wrst_req_ready_in_rst", {31'b0, req_ready}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("wrst_req_ready_after", {31'b0, req_ready}, 32'h1);
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         if (resp_valid) seen++;
         @(negedge clk);
      end
      chk("wrst_no_resp", 32'(seen), 32'd0);
      xact(0, 1'b0, 32'h44, '0, 4'hF, e, d, lat);
      chk("wrst_store_kept", d, 32'h0BADF00D);

      // Zero-latency instance
      xact(1, 1'b1, 32'h8, 32'h5A5A1234, 4'hF, e, d, lat);
      chk("l0_store_lat", 32'(lat), 32'd1);
      xact(1, 1'b0, 32'h8, '0, 4'hF, e, d, lat);
      chk("l0_load_lat", 32'(lat), 32'd1);
      chk("l0_load_rdata", d, 32'h5A5A1234);
      xact(1, 1'b0, 32'h401, '0, 4'hF, e, d, lat);
      chk("l0_err", {31'b0, e}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
